// File: rtl/fifo_frame_reader.sv
// Drains the audio FIFO into fixed-length sop/eop frames with 2-entry skid buffering, 2-cycle read-to-valid latency.
// Stalls reads once buffered+in-flight samples reach 2; DECIM_EN keeps every DECIM-th streamed sample.
module fifo_frame_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 10,
  parameter int FRAME_GAP  = 0,
  parameter int DECIM      = 2
) (
  input  logic                  CLK_50,
  input  logic                  Clear_in,
  input  logic                  Enable_in,
  input  logic                  Fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] Fifo_data_in,
  output logic                  Fifo_rden_out,
  output logic [DATA_WIDTH-1:0] Src_data_out,
  output logic                  Src_valid_out,
  output logic                  Src_sop_out,
  output logic                  Src_eop_out,
  input  logic                  Sink_ready_in,
  output logic                  Frame_done_out,
  output logic                  Busy_out,
  output logic [15:0]           Frame_cnt_out
);

  localparam int GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [CNT_W:0]   REQ_N    = (CNT_W + 1)'(FRAME_LEN);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_N    = GAP_W'(FRAME_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  if (FRAME_LEN < 2 || (1 << CNT_W) < FRAME_LEN || DECIM < 1) begin : g_param_err
    $error("fifo_frame_reader: illegal FRAME_LEN/CNT_W/DECIM");
  end

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              occ;
  logic                    pend, pend_keep, pend_gap;
  logic [DATA_WIDTH-1:0]   skid_0, skid_1;
  logic [CNT_W-1:0]        idx;
  logic [CNT_W:0]          req_cnt;
  logic [GAP_W-1:0]        gap_req, gap_cnt;
  logic                    pop, push, keep, last_hs, gap_done, rd_region;
  logic [2:0]              fill;

  assign Src_valid_out = (occ != 2'd0);
  assign Src_data_out  = skid_0;
  assign Src_sop_out   = Src_valid_out & (idx == '0);
  assign Src_eop_out   = Src_valid_out & (idx == IDX_LAST);
  assign Busy_out      = (state != IDLE);

  assign pop      = Src_valid_out & Sink_ready_in;
  assign last_hs  = pop & (idx == IDX_LAST);
  assign push     = pend & pend_keep;
  assign gap_done = (state == GAP) & pend & pend_gap & (gap_cnt == GAP_LAST);
  assign fill     = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};

  // Reads are confined to the samples the current frame or gap still needs.
  assign rd_region = ((state == STREAM) && (req_cnt != REQ_N)) ||
                     ((state == GAP) && (gap_req != GAP_N));

`ifdef DECIM_EN
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  logic [PH_W-1:0] ph;

  always_ff @(posedge CLK_50) begin
    if (Clear_in)
      ph <= '0;
    else if (Fifo_rden_out && (state == STREAM))
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
  end

  assign keep = (ph == '0);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    Fifo_rden_out = 1'b0;
    if (!Clear_in && rd_region && !Fifo_empty_in && (fill < 3'd2))
      Fifo_rden_out = 1'b1;
    case (state)
      IDLE: begin
        if (Enable_in)
          state_nxt = STREAM;
      end
      STREAM: begin
        if (last_hs) begin
          if (FRAME_GAP > 0)
            state_nxt = GAP;
          else if (!Enable_in)
            state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_done)
          state_nxt = Enable_in ? STREAM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (Clear_in) begin
      state          <= IDLE;
      occ            <= 2'd0;
      pend           <= 1'b0;
      pend_keep      <= 1'b0;
      pend_gap       <= 1'b0;
      skid_0         <= '0;
      skid_1         <= '0;
      idx            <= '0;
      req_cnt        <= '0;
      gap_req        <= '0;
      gap_cnt        <= '0;
      Frame_done_out <= 1'b0;
      Frame_cnt_out  <= 16'd0;
    end else begin
      state     <= state_nxt;
      pend      <= Fifo_rden_out;
      pend_keep <= Fifo_rden_out & (state == STREAM) & keep;
      pend_gap  <= Fifo_rden_out & (state == GAP);

      // Skid buffer: skid_0 is the head presented to the sink.
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0)
            skid_0 <= Fifo_data_in;
          else
            skid_1 <= Fifo_data_in;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid_0 <= skid_1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid_0 <= Fifo_data_in;
          end else begin
            skid_0 <= skid_1;
            skid_1 <= Fifo_data_in;
          end
        end
        default: ;
      endcase

      if (pop)
        idx <= last_hs ? '0 : idx + 1'b1;

      if (last_hs)
        req_cnt <= '0;
      else if (Fifo_rden_out && (state == STREAM) && keep)
        req_cnt <= req_cnt + 1'b1;

      if (gap_done) begin
        gap_req <= '0;
        gap_cnt <= '0;
      end else begin
        if (Fifo_rden_out && (state == GAP))
          gap_req <= gap_req + 1'b1;
        if (pend && pend_gap)
          gap_cnt <= gap_cnt + 1'b1;
      end

      Frame_done_out <= last_hs;
      if (last_hs)
        Frame_cnt_out <= Frame_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Two readers (frame gap 0 and 2) fed from incrementing FIFO models, scored against a frame-building reference.
module tb_fifo_frame_reader;

  localparam int L = 8;
`ifdef DECIM_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic clr, en, rdy, emp;
  int   base;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        rden [2];
  logic        vld  [2];
  logic        sop  [2];
  logic        eop  [2];
  logic        done [2];
  logic        busy [2];
  logic [23:0] sdat [2];
  logic [15:0] fcnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int G = 2 * g;
    int          ptr;
    logic [23:0] fq;
    exp_t        q[$];
    int          raw_need [100];
    int          popped, exp_frames;
    logic        hs_eop, l_vld, l_rdy;
    logic [23:0] l_dat;

    // FIFO model: holds base+1, base+2, ...; read data lands one cycle after the strobe.
    always @(posedge clk_50) begin
      if (clr)
        ptr <= 0;
      else if (rden[g]) begin
        fq  <= 24'(base + ptr + 1);
        ptr <= ptr + 1;
      end
    end

    fifo_frame_reader #(
      .DATA_WIDTH(24), .FRAME_LEN(L), .CNT_W(3), .FRAME_GAP(G), .DECIM(2)
    ) u_dut (
      .CLK_50(clk_50), .Clear_in(clr), .Enable_in(en), .Fifo_empty_in(emp),
      .Fifo_data_in(fq), .Fifo_rden_out(rden[g]), .Src_data_out(sdat[g]),
      .Src_valid_out(vld[g]), .Src_sop_out(sop[g]), .Src_eop_out(eop[g]),
      .Sink_ready_in(rdy), .Frame_done_out(done[g]), .Busy_out(busy[g]),
      .Frame_cnt_out(fcnt[g])
    );

    always @(negedge clk_50) begin : mon
      int   r, ph, n;
      exp_t e;
      if (clr) begin
        q.delete();
        r  = 0;
        ph = 0;
        for (int k = 0; k < 100; k++) begin
          n = 0;
          while (n < L) begin
            r++;
            if (ph == 0) begin
              e.d = 24'(base + r);
              e.s = (n == 0);
              e.e = (n == L - 1);
              q.push_back(e);
              n++;
            end
            ph = (ph + 1) % D;
          end
          r += G;
          raw_need[k] = r;
        end
        popped = 0; exp_frames = 0; hs_eop = 1'b0;
        l_vld = 1'b0; l_rdy = 1'b0; l_dat = '0;
      end else begin
        chk($sformatf("rd_while_empty%0d", g), rden[g] & emp, 0);
        chk($sformatf("rd_while_idle%0d", g), rden[g] & ~busy[g], 0);
        chk($sformatf("sop_unqual%0d", g), sop[g] & ~vld[g], 0);
        chk($sformatf("eop_unqual%0d", g), eop[g] & ~vld[g], 0);
        chk($sformatf("frame_done%0d", g), done[g], hs_eop);
        if (hs_eop) exp_frames++;
        chk($sformatf("frame_cnt%0d", g), fcnt[g], exp_frames % 65536);
        if (l_vld && !l_rdy) begin
          chk($sformatf("hold_vld%0d", g), vld[g], 1);
          chk($sformatf("hold_dat%0d", g), sdat[g], l_dat);
        end
        hs_eop = 1'b0;
        if (vld[g] && rdy) begin
          chk($sformatf("overrun%0d", g), q.size() == 0, 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("dat%0d", g), sdat[g], e.d);
            chk($sformatf("sop%0d", g), sop[g], e.s);
            chk($sformatf("eop%0d", g), eop[g], e.e);
            hs_eop = e.e;
            popped++;
          end
        end
        l_vld = vld[g]; l_rdy = rdy; l_dat = sdat[g];
      end
    end
  end

  task automatic cyc();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_vld"}, vld[i], 0);
      chk({tag, "_sop"}, sop[i], 0);
      chk({tag, "_eop"}, eop[i], 0);
      chk({tag, "_done"}, done[i], 0);
      chk({tag, "_busy"}, busy[i], 0);
      chk({tag, "_rden"}, rden[i], 0);
      chk({tag, "_fcnt"}, fcnt[i], 0);
      chk({tag, "_dat"}, sdat[i], 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 400 && !idle; c++) begin
      @(negedge clk_50);
      if (!busy[0] && !busy[1] && !vld[0] && !vld[1]) idle = 1'b1;
    end
    chk(tag, idle, 1);
  endtask

  task automatic chk_stop(input string tag);
    int p0, p1;
    chk({tag, "_align0"}, g_dut[0].popped % L, 0);
    chk({tag, "_align1"}, g_dut[1].popped % L, 0);
    chk({tag, "_raw0"}, g_dut[0].ptr, g_dut[0].raw_need[g_dut[0].popped / L - 1]);
    chk({tag, "_raw1"}, g_dut[1].ptr, g_dut[1].raw_need[g_dut[1].popped / L - 1]);
    p0 = g_dut[0].ptr;
    p1 = g_dut[1].ptr;
    repeat (20) cyc();
    chk({tag, "_noread0"}, g_dut[0].ptr, p0);
    chk({tag, "_noread1"}, g_dut[1].ptr, p1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hs, nrd0, late0, late1;
    bit  found;
    clr = 1'b1; en = 1'b0; rdy = 1'b1; emp = 1'b0; base = 0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk_zero_outputs("reset");

    // Back-to-back first frame at full rate.
    cyc();
    clr = 1'b0; en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk_50);
      if (vld[0] && sop[0]) found = 1'b1;
    end
    chk("first_sop", found, 1);
    hs = 0;
    for (int c = 0; c < L - 1; c++) begin
      @(negedge clk_50);
      hs += int'(vld[0] && rdy);
    end
    chk("full_rate", hs, L - 1);
    chk("first_eop", eop[0] & vld[0], 1);

    // Sink stall: at most two reads can be outstanding, none once full.
    cyc();
    rdy = 1'b0;
    nrd0 = 0; late0 = 0; late1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_50);
      nrd0 += int'(rden[0]);
      if (c >= 6) begin
        late0 += int'(rden[0]);
        late1 += int'(rden[1]);
      end
    end
    chk("stall_reads0", nrd0 <= 2, 1);
    chk("stall_full_rd0", late0, 0);
    chk("stall_full_rd1", late1, 0);
    chk("stall_vld0", vld[0], 1);
    chk("stall_vld1", vld[1], 1);
    cyc();
    rdy = 1'b1;

    // FIFO empty: buffer drains, no strobes.
    emp = 1'b1;
    repeat (6) @(negedge clk_50);
    chk("empty_drain0", vld[0], 0);
    chk("empty_drain1", vld[1], 0);
    repeat (14) cyc();
    emp = 1'b0;

    // Random backpressure and FIFO underflow.
    repeat (300) begin
      cyc();
      rdy = ($urandom % 4) != 0;
      emp = ($urandom % 6) == 0;
    end

    // Enable dropped mid-stream: frames complete, then reads stop.
    cyc();
    rdy = 1'b1; emp = 1'b0; en = 1'b0;
    wait_idle("stop_idle");
    chk_stop("stop");

    // Clear while stalled with data buffered and reads in flight.
    en = 1'b1; rdy = 1'b0;
    repeat (6) cyc();
    base = 1000;
    clr = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    chk_zero_outputs("clear");
    repeat (2) cyc();
    clr = 1'b0; rdy = 1'b1;
    repeat (80) begin
      cyc();
      rdy = ($urandom % 3) != 0;
      emp = ($urandom % 8) == 0;
    end
    cyc();
    rdy = 1'b1; emp = 1'b0; en = 1'b0;
    wait_idle("restart_idle");
    chk_stop("restart");
    chk("restart_frames0", g_dut[0].popped >= L, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
